rom_port_arbiter: RTL and testbench

- Shares one synchronous sprite/GUI ROM read port between N_REQ pixel-path requesters (e.g. GUI overlay, tank, bullet drawers).
- Round-robin valid/ready arbitration; tags each access and returns ROM data to the owning requester after a fixed latency.
- Sits beside the timing delay stages. Requesters compensate the fixed return latency with their own hcount/vcount/sync delay stages.

---
 rtl/rom_arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 28 ++
 rtl/rom_port_arbiter.sv | 94 +++++++++
 tb/tb_rom_port_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared constants and helpers for the sprite/GUI ROM port arbiter.
// Imported by rr_pick and rom_port_arbiter.
package rom_arb_pkg;

    localparam int N_REQ_DEF   = 3;
    localparam int AW_DEF      = 12;
    localparam int DW_DEF      = 12;
    localparam int ROM_LAT_DEF = 1;
    localparam int STAT_W      = 16;

    function automatic int onehot_to_idx(input logic [7:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: search starts one past ptr and wraps.
// Produces a one-hot grant, or zero when nothing is requested.
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Round-robin sharing of one synchronous ROM read port with tagged returns.
// Optional per-frame grant statistics under ROM_ARB_STATS_EN.
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int ROM_LAT = ROM_LAT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    vsync_in,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*AW-1:0]     addr,
    output logic [N_REQ-1:0]        gnt,
    output logic [AW-1:0]           rom_addr,
    input  logic [DW-1:0]           rom_data,
    output logic [DW-1:0]           rd_data,
    output logic [N_REQ-1:0]        rd_valid,
    output logic [N_REQ*STAT_W-1:0] stat_cnt
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    sel;
    logic [N_REQ-1:0] xfer;
    logic [N_REQ-1:0] tag [ROM_LAT+1];

    rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (gnt)
    );

    assign xfer = req & gnt;
    assign sel  = PW'(onehot_to_idx(8'(xfer)));

    // Tag stage 0 captures the owner; rd_valid is one register past the last stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr <= '0;
            rd_data  <= '0;
            rd_valid <= '0;
            ptr      <= PW'(N_REQ - 1);
            for (int k = 0; k <= ROM_LAT; k++) tag[k] <= '0;
        end else begin
            if (|xfer) begin
                rom_addr <= addr[sel*AW +: AW];
                ptr      <= sel;
            end
            tag[0] <= xfer;
            for (int k = 1; k <= ROM_LAT; k++) tag[k] <= tag[k-1];
            rd_data  <= rom_data;
            rd_valid <= tag[ROM_LAT];
        end
    end

`ifdef ROM_ARB_STATS_EN
    logic              vs_q;
    logic [STAT_W-1:0] cnt  [N_REQ];
    logic [STAT_W-1:0] stat [N_REQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q <= 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                cnt[i]  <= '0;
                stat[i] <= '0;
            end
        end else begin
            vs_q <= vsync_in;
            for (int i = 0; i < N_REQ; i++) begin
                if (vsync_in && !vs_q) begin
                    stat[i] <= cnt[i];
                    cnt[i]  <= {{(STAT_W-1){1'b0}}, xfer[i]};
                end else if (xfer[i] && cnt[i] != {STAT_W{1'b1}}) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_stat
        assign stat_cnt[g*STAT_W +: STAT_W] = stat[g];
    end
`else
    logic unused_vsync;
    assign unused_vsync = vsync_in;
    assign stat_cnt     = '0;
`endif

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: ROM_LAT=1 and ROM_LAT=3 instances share stimulus.
// Expected grants, returns and statistics come from a queue-based reference model.
module tb_rom_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 12;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vsync = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N*AW-1:0] addr = '0;

    logic [N-1:0]  gnt1, gnt3, rd_valid1, rd_valid3;
    logic [AW-1:0] rom_addr1, rom_addr3;
    logic [DW-1:0] rom_data1, rom_data3, rd_data1, rd_data3;
    logic [N*16-1:0] stat1, stat3;

    logic [DW-1:0] rp1;
    logic [DW-1:0] rp3 [3];

    typedef struct {
        int         due;
        logic [2:0] own;
        logic [11:0] data;
    } ret_t;

    ret_t q1[$];
    ret_t q3[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last = N - 1;
    logic [11:0] erom = '0;
    logic vs_prev = 1'b0;
    int cnt [3] = '{0, 0, 0};
    logic [47:0] estat = '0;
    logic just_rst = 1'b1;
    logic [47:0] frame_exp;

    always #5 clk = ~clk;

    rom_port_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .ROM_LAT(1)) u_l1 (
        .clk(clk), .rst(rst), .vsync_in(vsync), .req(req), .addr(addr),
        .gnt(gnt1), .rom_addr(rom_addr1), .rom_data(rom_data1),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .stat_cnt(stat1)
    );

    rom_port_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .ROM_LAT(3)) u_l3 (
        .clk(clk), .rst(rst), .vsync_in(vsync), .req(req), .addr(addr),
        .gnt(gnt3), .rom_addr(rom_addr3), .rom_data(rom_data3),
        .rd_data(rd_data3), .rd_valid(rd_valid3), .stat_cnt(stat3)
    );

    function automatic logic [11:0] romf(input logic [11:0] a);
        return {a[6:0], a[11:7]} ^ 12'h5A3;
    endfunction

    // Synchronous ROMs of latency 1 and 3
    always @(posedge clk) begin
        rp1    <= romf(rom_addr1);
        rp3[0] <= romf(rom_addr3);
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end
    assign rom_data1 = rp1;
    assign rom_data3 = rp3[2];

    function automatic int pick(input logic [2:0] r, input int lp);
        for (int k = 1; k <= N; k++) begin
            if (r[(lp + k) % N]) return (lp + k) % N;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [2:0]  ev;
        logic [11:0] ed;
        ev = '0;
        ed = '0;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            ev = q1[0].own;
            ed = q1[0].data;
            q1.delete(0);
        end
        chk("rd_valid_l1", 48'(rd_valid1), 48'(ev));
        if (ev != 0) chk("rd_data_l1", 48'(rd_data1), 48'(ed));
        ev = '0;
        ed = '0;
        if (q3.size() > 0 && q3[0].due == cyc) begin
            ev = q3[0].own;
            ed = q3[0].data;
            q3.delete(0);
        end
        chk("rd_valid_l3", 48'(rd_valid3), 48'(ev));
        if (ev != 0) chk("rd_data_l3", 48'(rd_data3), 48'(ed));
        chk("rom_addr_l1", 48'(rom_addr1), 48'(erom));
        chk("rom_addr_l3", 48'(rom_addr3), 48'(erom));
        chk("stat_l1", stat1, estat);
        chk("stat_l3", stat3, estat);
        if (just_rst) begin
            chk("rd_data_rst_l1", 48'(rd_data1), 48'(0));
            chk("rd_data_rst_l3", 48'(rd_data3), 48'(0));
        end
    endtask

    task automatic step(input logic [2:0] r, input logic [35:0] a,
                        input logic rs, input logic vs);
        int w;
        logic [2:0] eg;
        @(negedge clk);
        check_outputs();
        req   = r;
        addr  = a;
        rst   = rs;
        vsync = vs;
        #1;
        w  = pick(r, last);
        eg = (w >= 0) ? 3'(1 << w) : 3'b000;
        chk("gnt_l1", 48'(gnt1), 48'(eg));
        chk("gnt_l3", 48'(gnt3), 48'(eg));
        just_rst = rs;
        if (rs) begin
            last    = N - 1;
            erom    = '0;
            q1.delete();
            q3.delete();
            vs_prev = 1'b0;
            estat   = '0;
            cnt     = '{0, 0, 0};
        end else begin
            if (w >= 0) begin
                last = w;
                erom = a[w*AW +: AW];
                q1.push_back('{cyc + 3, eg, romf(a[w*AW +: AW])});
                q3.push_back('{cyc + 5, eg, romf(a[w*AW +: AW])});
            end
`ifdef ROM_ARB_STATS_EN
            for (int i = 0; i < N; i++) begin
                if (vs && !vs_prev) begin
                    estat[i*16 +: 16] = 16'(cnt[i]);
                    cnt[i] = (i == w) ? 1 : 0;
                end else if (i == w && cnt[i] < 65535) begin
                    cnt[i]++;
                end
            end
`endif
            vs_prev = vs;
        end
        cyc++;
    endtask

    initial begin
        // Reset
        step(3'b000, '0, 1'b1, 1'b0);
        step(3'b000, '0, 1'b1, 1'b0);
        // Single request from requester 0 at 0x010
        step(3'b001, {12'h000, 12'h000, 12'h010}, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(3'b000, '0, 1'b0, 1'b0);
        // All requesting continuously: rotation 0,1,2,0,...
        for (int i = 0; i < 9; i++)
            step(3'b111, {12'h300 + 12'(i), 12'h200 + 12'(i), 12'h100 + 12'(i)}, 1'b0, 1'b0);
        // Requester 1 pulse, idle gap, then all: next grant goes to 2
        step(3'b010, {12'h0, 12'h4AB, 12'h0}, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(3'b000, '0, 1'b0, 1'b0);
        step(3'b111, {12'h7C2, 12'h7B1, 12'h7A0}, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(3'b000, '0, 1'b0, 1'b0);
        // Reset with two reads in flight; first grant afterwards goes to 0
        step(3'b111, {12'h823, 12'h822, 12'h821}, 1'b0, 1'b0);
        step(3'b111, {12'h833, 12'h832, 12'h831}, 1'b0, 1'b0);
        step(3'b000, '0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(3'b000, '0, 1'b0, 1'b0);
        step(3'b111, {12'h903, 12'h902, 12'h901}, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(3'b000, '0, 1'b0, 1'b0);
        // Random sweep
        for (int i = 0; i < 400; i++)
            step(3'($urandom_range(0, 7)), 36'({$urandom, $urandom}), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(3'b000, '0, 1'b0, 1'b0);
        // One frame: 7 grants to requester 0, 3 to requester 2
        step(3'b000, '0, 1'b0, 1'b1);
        step(3'b000, '0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(3'b001, 36'({$urandom, $urandom}), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(3'b100, 36'({$urandom, $urandom}), 1'b0, 1'b0);
        step(3'b000, '0, 1'b0, 1'b0);
        step(3'b000, '0, 1'b0, 1'b1);
        step(3'b000, '0, 1'b0, 1'b0);
`ifdef ROM_ARB_STATS_EN
        frame_exp = {16'd3, 16'd0, 16'd7};
`else
        frame_exp = '0;
`endif
        chk("stat_frame_l1", stat1, frame_exp);
        chk("stat_frame_l3", stat3, frame_exp);
        for (int i = 0; i < 8; i++) step(3'b000, '0, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
